djs130_io_ctl: RTL and testbench
================================

// Module: djs130_io_ctl
// PURPOSE
//  I/O bus controller between the DJS-130 CPU and its peripherals (RTC and siblings).
//  Decodes a strobed I/O instruction, matches the device code and drives that device's 9-bit KZ control pulse.
//  Returns data and the SKP result to the CPU.
//  Also owns interrupt enable, the mask register, priority resolution and INTA, consuming each device's DMs, ZT and ZDQQ.
// PARAMETERS
//  N_DEV    4      number of attached devices; index 0 = highest interrupt priority
//  CPU_DMs  6'o77  pseudo-device code of the CPU (INTEN/INTDS/MSKO/INTA/IORST)
// PORTS
//  i_clk         in   1         system clock
//  i_rst_n       in   1         asynchronous, active-low reset
//  i_cpu_IOSTB   in   1         1-cycle strobe: i_cpu_IR valid
//  i_cpu_IR      in   16        I/O instr: [15:13]=3'b011, [12:11] AC, [10:8] op, [7:6] ctl, [5:0] device
//  i_cpu_AC      in   16        accumulator value for DOx / MSKO
//  i_cpu_INTACK  in   1         CPU accepted interrupt; clears ION
//  o_cpu_IOBUSY  out  1         transaction in progress; strobes ignored
//  o_cpu_IORDY   out  1         1-cycle completion pulse
//  o_cpu_DATA    out  16        DIx/INTA result, valid with IORDY, else 0
//  o_cpu_SKIP    out  1         SKP result, valid with IORDY, else 0
//  o_cpu_INTR    out  1         interrupt request to CPU
//  o_dev_SR      out  16        broadcast output data (latched AC)
//  o_dev_KZ      out  9*N_DEV   per-device KZ; slice i = [9i+8:9i]
//  o_dev_ZZ0     out  1         device master clear
//  i_dev_DMs     in   6*N_DEV   device codes
//  i_dev_ZT      in   2*N_DEV   per-device {done,busy}
//  i_dev_ZDQQ    in   N_DEV     per-device interrupt request
//  i_dev_DATA    in   16*N_DEV  per-device read data (tie 0 if none)
// BEHAVIOUR
//  Reset: FSM=IDLE; ION=0; MASK=0; all outputs 0 except o_dev_ZZ0=1 while i_rst_n low.
//  FSM IDLE -> DEC -> EXEC -> DONE -> IDLE.
//   IDLE: IOSTB latches IR and AC; IOSTB outside IDLE is dropped.
//   DEC: op/ctl/device decode. Match = lowest index i with DMs[i]==IR[5:0]. CPU_DMs is checked first.
//   EXEC: exactly one-cycle KZ pulse to the matched slice; DIx data captured from i_dev_DATA this cycle.
//   DONE: IORDY=1 with DATA/SKIP. IOSTB->IORDY latency fixed at 3 cycles.
//  IOBUSY=1 in DEC/EXEC/DONE; back-to-back strobes are legal from the cycle after IORDY.
//  KZ bits: 0 DOA, 1 DOB, 2 DOC, 3 DIA, 4 DIB, 5 DIC, 6 S, 7 C, 8 P.
//   op bit and ctl bit are set together in EXEC; NIO sets ctl only.
//  SKP (op 111): no KZ. ctl selects the test: 00 busy!=0, 01 busy==0, 10 done!=0, 11 done==0. ZT is sampled in EXEC.
//  No device match: no KZ, DATA=0, SKIP=0, IORDY still at 3 cycles.
//  CPU_DMs ops:
//   NIO S -> ION=1; NIO C -> ION=0.
//   DOB (MSKO) -> MASK=AC.
//   DIB (INTA) -> DATA={10'b0, DMs of highest-priority unmasked requester}, 0 if none.
//   DIC C (IORST) -> o_dev_ZZ0=1 for one cycle in EXEC, and MASK=0.
//   SKP tests ION in place of busy; done tests read 0.
//  Mask: device i is masked when MASK[15-i]=1. N_DEV<=16.
//  INTR = ION & |(ZDQQ & ~mask), registered, so there is 1 cycle lag.
//  INTACK clears ION next cycle. If INTACK and NIO S coincide in EXEC, NIO S wins.
//  A mid-transaction reset aborts to IDLE with no IORDY and no KZ, and asserts ZZ0.
// STRUCTURE
//  djs130_io_defs.vh: op codes, ctl codes, KZ bit indices, SKP test codes, FSM state encodings.
//  Sub-module djs130_int_prio: N_DEV-wide fixed-priority encoder over req&~mask.
//   Outputs: any, idx, DMs.
// TESTING
//  1. Reset: i_rst_n=0 mid-DEC -> IORDY never pulses; all KZ=0; ZZ0=1 until release; MASK=0.
//  2. RTC@14, DOA 2,14 S with AC=3 -> 3 cycles after IOSTB, KZ slice=9'b001000001 for 1 cycle; SR=3; IORDY=1.
//  3. RTC ZT=2'b10, SKP DN 14 -> SKIP=1. SKP DZ -> SKIP=0. SKP to unmatched code 33 -> SKIP=0, IORDY at 3 cycles.
//  4. Devices 0 and 2 assert ZDQQ, NIO S 77 -> INTR=1. MSKO AC=16'h8000 -> INTA returns DMs[2].
//     MSKO AC=16'hA000 -> INTA returns 0 and INTR=0.
//  5. INTACK -> ION=0, INTR drops next cycle. INTACK coincident with NIO S 77 in EXEC -> ION=1.
//  6. IOSTB repeated during IOBUSY -> ignored: exactly one KZ pulse and one IORDY.
//     IORST (DIC C 77) -> ZZ0 is a 1-cycle pulse and MASK=0.

Source files
------------

// File: rtl/djs130_io_ctl_pkg.sv
// Shared definitions for the DJS-130 I/O bus controller.
//   - I/O instruction field encodings (op, control, skip tests)
//   - KZ control-pulse bit positions within a 9-bit device slice
//   - controller FSM state type
//   - helpers that build a KZ slice and evaluate a skip test
package djs130_io_ctl_pkg;

    localparam int IDX_W = 4;   // device index width, supports up to 16 devices
    localparam int KZ_W  = 9;   // KZ bits per device

    // IR[15:13] of every I/O instruction
    localparam logic [2:0] IO_PREFIX = 3'b011;

    // IR[10:8]
    localparam logic [2:0] OP_NIO = 3'b000;
    localparam logic [2:0] OP_DIA = 3'b001;
    localparam logic [2:0] OP_DOA = 3'b010;
    localparam logic [2:0] OP_DIB = 3'b011;
    localparam logic [2:0] OP_DOB = 3'b100;
    localparam logic [2:0] OP_DIC = 3'b101;
    localparam logic [2:0] OP_DOC = 3'b110;
    localparam logic [2:0] OP_SKP = 3'b111;

    // IR[7:6] for non-skip instructions
    localparam logic [1:0] CTL_NONE = 2'b00;
    localparam logic [1:0] CTL_S    = 2'b01;
    localparam logic [1:0] CTL_C    = 2'b10;
    localparam logic [1:0] CTL_P    = 2'b11;

    // IR[7:6] for SKP
    localparam logic [1:0] SKP_BN = 2'b00;
    localparam logic [1:0] SKP_BZ = 2'b01;
    localparam logic [1:0] SKP_DN = 2'b10;
    localparam logic [1:0] SKP_DZ = 2'b11;

    // KZ bit positions
    localparam int KZ_DOA = 0;
    localparam int KZ_DOB = 1;
    localparam int KZ_DOC = 2;
    localparam int KZ_DIA = 3;
    localparam int KZ_DIB = 4;
    localparam int KZ_DIC = 5;
    localparam int KZ_S   = 6;
    localparam int KZ_C   = 7;
    localparam int KZ_P   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEC  = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } io_state_e;

    // KZ slice for one instruction: op bit plus control bit.
    // SKP never pulses KZ; NIO contributes only its control bit.
    function automatic logic [KZ_W-1:0] kz_pattern(input logic [2:0] op,
                                                   input logic [1:0] ctl);
        logic [KZ_W-1:0] p;
        p = '0;
        case (op)
            OP_DOA:  p[KZ_DOA] = 1'b1;
            OP_DOB:  p[KZ_DOB] = 1'b1;
            OP_DOC:  p[KZ_DOC] = 1'b1;
            OP_DIA:  p[KZ_DIA] = 1'b1;
            OP_DIB:  p[KZ_DIB] = 1'b1;
            OP_DIC:  p[KZ_DIC] = 1'b1;
            default: ;
        endcase
        if (op != OP_SKP) begin
            case (ctl)
                CTL_S:   p[KZ_S] = 1'b1;
                CTL_C:   p[KZ_C] = 1'b1;
                CTL_P:   p[KZ_P] = 1'b1;
                default: ;
            endcase
        end
        return p;
    endfunction

    function automatic logic skp_eval(input logic [1:0] ctl,
                                      input logic       busy,
                                      input logic       done);
        logic r;
        case (ctl)
            SKP_BN:  r = busy;
            SKP_BZ:  r = ~busy;
            SKP_DN:  r = done;
            default: r = ~done;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/djs130_int_prio.sv
// Fixed-priority interrupt encoder. Index 0 is the highest priority.
// Ports:
//   req     in   N_DEV     per-device interrupt request
//   mask    in   N_DEV     per-device mask (1 = masked), already in device order
//   dms     in   6*N_DEV   device codes, slice i = [6i+5:6i]
//   any     out  1         some unmasked request is pending
//   idx     out  IDX_W     index of the winning device (0 when none)
//   dms_sel out  6         device code of the winner (0 when none)
module djs130_int_prio
    import djs130_io_ctl_pkg::*;
#(
    parameter int N_DEV = 4
) (
    input  logic [N_DEV-1:0]   req,
    input  logic [N_DEV-1:0]   mask,
    input  logic [6*N_DEV-1:0] dms,
    output logic               any,
    output logic [IDX_W-1:0]   idx,
    output logic [5:0]         dms_sel
);

    // Scan from the lowest priority upward so the lowest index assigned last wins.
    always_comb begin
        any     = 1'b0;
        idx     = '0;
        dms_sel = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (req[i] && !mask[i]) begin
                any     = 1'b1;
                idx     = IDX_W'(i);
                dms_sel = dms[6*i +: 6];
            end
        end
    end

endmodule

// File: rtl/djs130_io_ctl.sv
// DJS-130 I/O bus controller. Accepts a strobed I/O instruction from the CPU,
// matches its device code against the attached devices (CPU pseudo-device
// first), pulses the matched device's KZ slice for one cycle, and returns
// read data / skip result with a fixed 3-cycle strobe-to-ready latency.
// Also holds interrupt enable (ION), the interrupt mask, and drives INTR.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_cpu_IOSTB/IR/AC       instruction strobe, instruction word, accumulator
//   i_cpu_INTACK            CPU took the interrupt; clears ION
//   o_cpu_IOBUSY/IORDY      busy flag, 1-cycle completion pulse
//   o_cpu_DATA/SKIP         result, non-zero only alongside IORDY
//   o_cpu_INTR              registered interrupt request
//   o_dev_SR                latched AC broadcast to devices
//   o_dev_KZ                per-device 9-bit control pulses
//   o_dev_ZZ0               device master clear (reset or IORST)
//   i_dev_DMs/ZT/ZDQQ/DATA  per-device code, {done,busy}, int request, read data
//   o_dbg_state             current controller FSM state
// Handshake: a strobe is accepted only while IOBUSY is low; IORDY pulses for
// one cycle exactly three cycles after the accepted strobe, and a new strobe
// may be presented in the cycle after IORDY.
module djs130_io_ctl
    import djs130_io_ctl_pkg::*;
#(
    parameter int         N_DEV   = 4,      // 1..16 devices
    parameter logic [5:0] CPU_DMs = 6'o77
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cpu_IOSTB,
    input  logic [15:0]         i_cpu_IR,
    input  logic [15:0]         i_cpu_AC,
    input  logic                i_cpu_INTACK,
    output logic                o_cpu_IOBUSY,
    output logic                o_cpu_IORDY,
    output logic [15:0]         o_cpu_DATA,
    output logic                o_cpu_SKIP,
    output logic                o_cpu_INTR,
    output logic [15:0]         o_dev_SR,
    output logic [9*N_DEV-1:0]  o_dev_KZ,
    output logic                o_dev_ZZ0,
    input  logic [6*N_DEV-1:0]  i_dev_DMs,
    input  logic [2*N_DEV-1:0]  i_dev_ZT,
    input  logic [N_DEV-1:0]    i_dev_ZDQQ,
    input  logic [16*N_DEV-1:0] i_dev_DATA,
    output logic [1:0]          o_dbg_state
);

    io_state_e        state_q, state_d;

    logic             is_io_q;
    logic [2:0]       op_q;
    logic [1:0]       ctl_q;
    logic [5:0]       dev_q;
    logic [15:0]      sr_q;

    logic             cpu_q, hit_q;
    logic [IDX_W-1:0] idx_q;

    logic [15:0]      data_q;
    logic             skip_q;

    logic             ion_q, intr_q;
    logic [15:0]      mask_q;

    logic             dev_hit;
    logic [IDX_W-1:0] dev_idx;
    logic             dev_busy, dev_done;
    logic [15:0]      dev_rdata;
    logic [15:0]      exec_data;
    logic             exec_skip;
    logic             in_exec, iorst;

    logic [N_DEV-1:0] dev_mask;
    logic             prio_any;
    logic [IDX_W-1:0] prio_idx_unused;
    logic [5:0]       prio_dms;

    // Accumulator-select field of IR and mask bits above N_DEV carry no meaning here.
    logic             unused_bits;
    assign unused_bits = ^{i_cpu_IR[12:11], mask_q};

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        o_cpu_IOBUSY = 1'b1;
        o_cpu_IORDY  = 1'b0;
        o_cpu_DATA   = '0;
        o_cpu_SKIP   = 1'b0;
        in_exec      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_cpu_IOBUSY = 1'b0;
                if (i_cpu_IOSTB) state_d = ST_DEC;
            end
            ST_DEC:  state_d = ST_EXEC;
            ST_EXEC: begin
                in_exec = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                o_cpu_IORDY = 1'b1;
                o_cpu_DATA  = data_q;
                o_cpu_SKIP  = skip_q;
                state_d     = ST_IDLE;
            end
        endcase
    end

    assign o_dbg_state = state_q;

    // ---------------- instruction latch ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            is_io_q <= 1'b0;
            op_q    <= '0;
            ctl_q   <= '0;
            dev_q   <= '0;
            sr_q    <= '0;
        end else if (state_q == ST_IDLE && i_cpu_IOSTB) begin
            is_io_q <= (i_cpu_IR[15:13] == IO_PREFIX);
            op_q    <= i_cpu_IR[10:8];
            ctl_q   <= i_cpu_IR[7:6];
            dev_q   <= i_cpu_IR[5:0];
            sr_q    <= i_cpu_AC;
        end
    end

    assign o_dev_SR = sr_q;

    // ---------------- decode ----------------
    // Lowest matching index wins when several devices share a code.
    always_comb begin
        dev_hit = 1'b0;
        dev_idx = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (i_dev_DMs[6*i +: 6] == dev_q) begin
                dev_hit = 1'b1;
                dev_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cpu_q <= 1'b0;
            hit_q <= 1'b0;
            idx_q <= '0;
        end else if (state_q == ST_DEC) begin
            cpu_q <= is_io_q && (dev_q == CPU_DMs);
            hit_q <= is_io_q && (dev_q != CPU_DMs) && dev_hit;
            idx_q <= dev_idx;
        end
    end

    // ---------------- execute ----------------
    always_comb begin
        dev_busy  = 1'b0;
        dev_done  = 1'b0;
        dev_rdata = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                dev_busy  = i_dev_ZT[2*i];
                dev_done  = i_dev_ZT[2*i+1];
                dev_rdata = i_dev_DATA[16*i +: 16];
            end
        end
    end

    // The CPU pseudo-device reports ION as "busy" and never reports done.
    always_comb begin
        exec_data = '0;
        exec_skip = 1'b0;
        if (cpu_q) begin
            if (op_q == OP_DIB && prio_any) exec_data = {10'b0, prio_dms};
            if (op_q == OP_SKP)             exec_skip = skp_eval(ctl_q, ion_q, 1'b0);
        end else if (hit_q) begin
            if (op_q == OP_DIA || op_q == OP_DIB || op_q == OP_DIC) exec_data = dev_rdata;
            if (op_q == OP_SKP) exec_skip = skp_eval(ctl_q, dev_busy, dev_done);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q <= '0;
            skip_q <= 1'b0;
        end else if (in_exec) begin
            data_q <= exec_data;
            skip_q <= exec_skip;
        end
    end

    always_comb begin
        o_dev_KZ = '0;
        if (in_exec && hit_q) begin
            for (int i = 0; i < N_DEV; i++) begin
                if (idx_q == IDX_W'(i)) o_dev_KZ[KZ_W*i +: KZ_W] = kz_pattern(op_q, ctl_q);
            end
        end
    end

    assign iorst     = in_exec && cpu_q && op_q == OP_DIC && ctl_q == CTL_C;
    assign o_dev_ZZ0 = !i_rst_n || iorst;

    // ---------------- interrupts ----------------
    always_comb begin
        dev_mask = '0;
        for (int i = 0; i < N_DEV; i++) dev_mask[i] = mask_q[15-i];
    end

    djs130_int_prio #(
        .N_DEV (N_DEV)
    ) u_prio (
        .req     (i_dev_ZDQQ),
        .mask    (dev_mask),
        .dms     (i_dev_DMs),
        .any     (prio_any),
        .idx     (prio_idx_unused),
        .dms_sel (prio_dms)
    );

    // Later assignments take precedence: an NIO S in EXEC overrides a coincident INTACK.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ion_q  <= 1'b0;
            mask_q <= '0;
        end else begin
            if (i_cpu_INTACK) ion_q <= 1'b0;
            if (in_exec && cpu_q) begin
                if (op_q == OP_NIO && ctl_q == CTL_S)      ion_q <= 1'b1;
                else if (op_q == OP_NIO && ctl_q == CTL_C) ion_q <= 1'b0;
                if (op_q == OP_DOB)  mask_q <= sr_q;
                else if (iorst)      mask_q <= '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) intr_q <= 1'b0;
        else          intr_q <= ion_q && prio_any;
    end

    assign o_cpu_INTR = intr_q;

endmodule

// File: tb/tb_djs130_io_ctl.sv
module tb_djs130_io_ctl;

    localparam int         N_DEV = 4;
    localparam logic [5:0] CPU   = 6'o77;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic                i_cpu_IOSTB = 1'b0;
    logic [15:0]         i_cpu_IR = '0;
    logic [15:0]         i_cpu_AC = '0;
    logic                i_cpu_INTACK = 1'b0;
    logic                o_cpu_IOBUSY, o_cpu_IORDY, o_cpu_SKIP, o_cpu_INTR, o_dev_ZZ0;
    logic [15:0]         o_cpu_DATA, o_dev_SR;
    logic [9*N_DEV-1:0]  o_dev_KZ;
    logic [6*N_DEV-1:0]  i_dev_DMs;
    logic [2*N_DEV-1:0]  i_dev_ZT;
    logic [N_DEV-1:0]    i_dev_ZDQQ;
    logic [16*N_DEV-1:0] i_dev_DATA;
    logic [1:0]          o_dbg_state;

    logic [5:0]  dms[N_DEV];
    logic [1:0]  zt[N_DEV];     // {done,busy}
    logic [15:0] ddata[N_DEV];
    logic [N_DEV-1:0] zdqq;

    always_comb begin
        for (int i = 0; i < N_DEV; i++) begin
            i_dev_DMs[6*i +: 6]    = dms[i];
            i_dev_ZT[2*i +: 2]     = zt[i];
            i_dev_DATA[16*i +: 16] = ddata[i];
        end
        i_dev_ZDQQ = zdqq;
    end

    djs130_io_ctl #(.N_DEV(N_DEV), .CPU_DMs(CPU)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_cpu_IOSTB  (i_cpu_IOSTB),
        .i_cpu_IR     (i_cpu_IR),
        .i_cpu_AC     (i_cpu_AC),
        .i_cpu_INTACK (i_cpu_INTACK),
        .o_cpu_IOBUSY (o_cpu_IOBUSY),
        .o_cpu_IORDY  (o_cpu_IORDY),
        .o_cpu_DATA   (o_cpu_DATA),
        .o_cpu_SKIP   (o_cpu_SKIP),
        .o_cpu_INTR   (o_cpu_INTR),
        .o_dev_SR     (o_dev_SR),
        .o_dev_KZ     (o_dev_KZ),
        .o_dev_ZZ0    (o_dev_ZZ0),
        .i_dev_DMs    (i_dev_DMs),
        .i_dev_ZT     (i_dev_ZT),
        .i_dev_ZDQQ   (i_dev_ZDQQ),
        .i_dev_DATA   (i_dev_DATA),
        .o_dbg_state  (o_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [48:0] exp_rdy_q[$];   // {cycle, data, skip}
    logic [67:0] exp_kz_q[$];    // {cycle, kz}
    logic [31:0] exp_zz_q[$];    // cycle of an IORST pulse

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit          ref_ion  = 1'b0;
    logic [15:0] ref_mask = '0;
    int op_kz_bit[8]  = '{-1, 3, 0, 4, 1, 5, 2, -1};  // NIO DIA DOA DIB DOB DIC DOC SKP
    int ctl_kz_bit[4] = '{-1, 6, 7, 8};

    function automatic logic [15:0] inta_value();
        for (int i = 0; i < N_DEV; i++)
            if (zdqq[i] && !ref_mask[15-i]) return {10'b0, dms[i]};
        return 16'h0;
    endfunction

    function automatic logic intr_exp();
        logic r = 1'b0;
        for (int i = 0; i < N_DEV; i++)
            if (zdqq[i] && !ref_mask[15-i]) r = 1'b1;
        return ref_ion && r;
    endfunction

    function automatic logic skip_rule(input logic [1:0] ctl, input logic busy, input logic done);
        case (ctl)
            2'd0:    return busy;
            2'd1:    return !busy;
            2'd2:    return done;
            default: return !done;
        endcase
    endfunction

    task automatic model(input logic [2:0] op, input logic [1:0] ctl, input logic [5:0] dev,
                         input logic [15:0] ac, output logic [9*N_DEV-1:0] kz,
                         output logic [15:0] d, output logic s, output logic z);
        int hit = -1;
        int kb;
        kz = '0; d = '0; s = 1'b0; z = 1'b0;
        if (dev == CPU) begin
            case (op)
                3'd0: if (ctl == 2'd1) ref_ion = 1'b1; else if (ctl == 2'd2) ref_ion = 1'b0;
                3'd3: d = inta_value();
                3'd4: ref_mask = ac;
                3'd5: if (ctl == 2'd2) begin z = 1'b1; ref_mask = '0; end
                3'd7: s = skip_rule(ctl, ref_ion, 1'b0);
                default: ;
            endcase
        end else begin
            for (int i = 0; i < N_DEV && hit < 0; i++) if (dms[i] == dev) hit = i;
            if (hit >= 0) begin
                if (op == 3'd7) begin
                    s = skip_rule(ctl, zt[hit][0], zt[hit][1]);
                end else begin
                    kb = op_kz_bit[op];
                    if (kb >= 0) kz[9*hit + kb] = 1'b1;
                    kb = ctl_kz_bit[ctl];
                    if (kb >= 0) kz[9*hit + kb] = 1'b1;
                    if (op == 3'd1 || op == 3'd3 || op == 3'd5) d = ddata[hit];
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        while (o_cpu_IOBUSY && n < 20) begin
            @(posedge i_clk); #1;
            n++;
        end
        check("wait_idle_timeout", o_cpu_IOBUSY, 0);
    endtask

    task automatic settle();
        wait_idle();
        repeat (2) begin @(posedge i_clk); #1; end
    endtask

    // hold: cycles IOSTB stays high; intack: pulse INTACK during the EXEC cycle
    task automatic issue(input logic [2:0] op, input logic [1:0] ctl, input logic [5:0] dev,
                         input logic [15:0] ac, input int hold, input bit intack);
        logic [9*N_DEV-1:0] kz;
        logic [15:0] d;
        logic s, z;
        int c;
        wait_idle();
        model(op, ctl, dev, ac, kz, d, s, z);
        c = cyc;
        exp_rdy_q.push_back({32'(c + 3), d, s});
        if (kz != '0) exp_kz_q.push_back({32'(c + 2), kz});
        if (z) exp_zz_q.push_back(32'(c + 2));
        i_cpu_IR    = {3'b011, 2'($urandom_range(0, 3)), op, ctl, dev};
        i_cpu_AC    = ac;
        i_cpu_IOSTB = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge i_clk); #1;
            i_cpu_IOSTB  = (k < hold);
            i_cpu_INTACK = intack && (k == 2);
        end
        i_cpu_INTACK = 1'b0;
        check("sr", o_dev_SR, ac);
    endtask

    // ---------------- monitor ----------------
    logic [48:0] m_rdy;
    logic [67:0] m_kz;
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (exp_rdy_q.size() > 0 && exp_rdy_q[0][48:17] == 32'(cyc)) begin
                m_rdy = exp_rdy_q.pop_front();
                check("iordy", o_cpu_IORDY, 1);
                check("data", o_cpu_DATA, m_rdy[16:1]);
                check("skip", o_cpu_SKIP, m_rdy[0]);
            end else begin
                check("iordy_idle", o_cpu_IORDY, 0);
                check("data_idle", {o_cpu_DATA, o_cpu_SKIP}, 0);
            end
            if (exp_kz_q.size() > 0 && exp_kz_q[0][67:36] == 32'(cyc)) begin
                m_kz = exp_kz_q.pop_front();
                check("kz", o_dev_KZ, m_kz[35:0]);
            end else begin
                check("kz_idle", o_dev_KZ, 0);
            end
            if (exp_zz_q.size() > 0 && exp_zz_q[0] == 32'(cyc)) begin
                void'(exp_zz_q.pop_front());
                check("zz0_pulse", o_dev_ZZ0, 1);
            end else begin
                check("zz0_idle", o_dev_ZZ0, 0);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic check_reset_outputs();
        check("rst_zz0", o_dev_ZZ0, 1);
        check("rst_kz", o_dev_KZ, 0);
        check("rst_iordy", o_cpu_IORDY, 0);
        check("rst_busy", o_cpu_IOBUSY, 0);
        check("rst_data", {o_cpu_DATA, o_cpu_SKIP}, 0);
        check("rst_intr", o_cpu_INTR, 0);
        check("rst_sr", o_dev_SR, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [2:0]  r_op;
    logic [1:0]  r_ctl;
    logic [5:0]  r_dev;
    int          r_sel;

    initial begin
        dms[0] = 6'o14; dms[1] = 6'o20; dms[2] = 6'o21; dms[3] = 6'o14;
        for (int i = 0; i < N_DEV; i++) begin
            zt[i]    = 2'b00;
            ddata[i] = 16'h1000 + 16'(i);
        end
        zdqq = '0;

        // power-on reset
        repeat (2) @(negedge i_clk);
        check_reset_outputs();
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // RTC DOA S with AC=3
        issue(3'd2, 2'd1, 6'o14, 16'd3, 1, 0);
        settle();
        check("sr_rtc", o_dev_SR, 16'd3);

        // skip tests on RTC and on an unmatched code
        zt[0] = 2'b10;
        issue(3'd7, 2'd2, 6'o14, 16'h0, 1, 0);   // SKPDN -> 1
        issue(3'd7, 2'd3, 6'o14, 16'h0, 1, 0);   // SKPDZ -> 0
        issue(3'd7, 2'd2, 6'o33, 16'h0, 1, 0);   // unmatched -> 0
        zt[0] = 2'b01;
        issue(3'd7, 2'd0, 6'o14, 16'h0, 1, 0);   // SKPBN -> 1
        issue(3'd7, 2'd1, 6'o14, 16'h0, 1, 0);   // SKPBZ -> 0
        issue(3'd3, 2'd0, 6'o14, 16'h0, 1, 0);   // DIB from RTC (dev 0, not dev 3)

        // interrupts and mask
        zdqq = 4'b0101;
        issue(3'd0, 2'd1, CPU, 16'h0, 1, 0);      // NIO S 77
        settle();
        check("intr_on", o_cpu_INTR, intr_exp());
        issue(3'd4, 2'd0, CPU, 16'h8000, 1, 0);   // MSKO
        issue(3'd3, 2'd0, CPU, 16'h0, 1, 0);      // INTA -> DMs[2]
        issue(3'd4, 2'd0, CPU, 16'hA000, 1, 0);
        issue(3'd3, 2'd0, CPU, 16'h0, 1, 0);      // INTA -> 0
        settle();
        check("intr_masked", o_cpu_INTR, intr_exp());
        issue(3'd7, 2'd0, CPU, 16'h0, 1, 0);      // SKP BN 77 with ION=1

        // INTACK clears ION; INTACK coincident with NIO S keeps ION
        issue(3'd4, 2'd0, CPU, 16'h0, 1, 0);
        settle();
        check("intr_pre_ack", o_cpu_INTR, intr_exp());
        i_cpu_INTACK = 1'b1;
        @(posedge i_clk); #1;
        i_cpu_INTACK = 1'b0;
        ref_ion = 1'b0;
        @(posedge i_clk); #1;
        check("intr_after_ack", o_cpu_INTR, intr_exp());
        issue(3'd0, 2'd1, CPU, 16'h0, 1, 1);
        settle();
        check("intr_nios_wins", o_cpu_INTR, intr_exp());

        // repeated strobes during busy, then IORST
        issue(3'd6, 2'd3, 6'o20, 16'h5A5A, 3, 0);
        issue(3'd4, 2'd0, CPU, 16'h8000, 1, 0);
        issue(3'd5, 2'd2, CPU, 16'h0, 1, 0);      // IORST
        issue(3'd3, 2'd0, CPU, 16'h0, 1, 0);      // INTA -> DMs[0] when mask cleared
        settle();

        // reset in the middle of DEC
        issue(3'd4, 2'd0, CPU, 16'h8000, 1, 0);
        wait_idle();
        i_cpu_IR    = {3'b011, 2'b00, 3'd2, 2'd1, 6'o14};
        i_cpu_AC    = 16'h0055;
        i_cpu_IOSTB = 1'b1;
        @(posedge i_clk); #1;
        i_cpu_IOSTB = 1'b0;
        i_rst_n     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check_reset_outputs();
        end
        @(posedge i_clk); #1;
        i_rst_n  = 1'b1;
        ref_ion  = 1'b0;
        ref_mask = '0;
        issue(3'd3, 2'd0, CPU, 16'h0, 1, 0);      // INTA -> DMs[0]: mask was cleared
        settle();
        check("intr_post_reset", o_cpu_INTR, intr_exp());

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            wait_idle();
            for (int i = 0; i < N_DEV; i++) begin
                zt[i]    = 2'($urandom_range(0, 3));
                ddata[i] = 16'($urandom);
            end
            zdqq  = 4'($urandom_range(0, 15));
            r_sel = int'($urandom_range(0, 9));
            if (r_sel < 6)      r_dev = dms[$urandom_range(0, N_DEV - 1)];
            else if (r_sel < 8) r_dev = CPU;
            else                r_dev = 6'($urandom_range(0, 63));
            r_op  = 3'($urandom_range(0, 7));
            r_ctl = 2'($urandom_range(0, 3));
            issue(r_op, r_ctl, r_dev, 16'($urandom), 1, 0);
            if (n % 4 == 3) begin
                settle();
                check("intr_rand", o_cpu_INTR, intr_exp());
            end
        end

        settle();
        repeat (4) begin @(posedge i_clk); #1; end
        check("rdy_q_drained", 64'(exp_rdy_q.size()), 0);
        check("kz_q_drained", 64'(exp_kz_q.size()), 0);
        check("zz_q_drained", 64'(exp_zz_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
